bsc_chain_scan_ctrl: RTL and testbench
======================================

Name: bsc_chain_scan_ctrl

Overview:
Command-driven sequencer for the four-way boundary-scan chain bank.
- Accepts one scan command at a time from a host: target chain, capture/update flags, mode, write vector.
- Drives chain select, capture/shift/update enables and serial data for exactly the selected chain's length.
- Collects the shifted-out bits and returns them on a valid/ready response channel.
- Sits between the test host (or TAP instruction decoder) and the multi-chain BSC bank.

Parameters:
LEN0, 6, cell count of chain 0
LEN1, 5, cell count of chain 1
LEN2, 0, cell count of chain 2 (0 = chain absent)
LEN3, 0, cell count of chain 3 (0 = chain absent)
MAX_LEN, 16, width of write/read vectors; every LENn must be <= MAX_LEN (checked at elaboration)

Ports:
clk  in  1  single clock; also feeds the chain capture/update clocks at integration
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  controller can accept a command
cmd_chain  in  2  target chain index
cmd_capture  in  1  perform capture before shifting
cmd_update  in  1  perform update after shifting
cmd_mode  in  1  value driven on inst_mode for the whole operation
cmd_wdata  in  MAX_LEN  bits to shift in, LSB first
rsp_valid  out  1  response available
rsp_ready  in  1  host accepts response
rsp_rdata  out  MAX_LEN  bits shifted out; bit i = i-th bit out
rsp_err  out  1  target chain has length 0
mux_select  out  2  chain select to bank
inst_capture_en  out  1  capture/shift flop enable
inst_update_en  out  1  update flop enable
inst_shift_dr  out  1  shift mux select
inst_mode  out  1  test mux select
inst_data_in  out  1  serial data into selected chain
data_out_inst  in  1  serial data out of selected chain

Behaviour:
- Reset values (async, immediate): state IDLE; cmd_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mux_select=0; all inst_* enables=0; inst_mode=0; inst_data_in=0; bit counter=0.
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid && cmd_ready, latch chain, flags, mode and wdata, and set L = LEN[chain].
  - Next state: CAPTURE if cmd_capture; else SHIFT if L>0; else UPDATE if cmd_update; else RESP.
- mux_select and inst_mode are registered from the latched command from the cycle after acceptance until RESP exits. They never change mid-operation.
- CAPTURE: exactly 1 cycle; inst_capture_en=1, inst_shift_dr=0. Next state: SHIFT if L>0, else UPDATE/RESP per cmd_update.
- SHIFT: exactly L cycles.
  - inst_capture_en=1, inst_shift_dr=1.
  - inst_data_in = wdata[k] on shift cycle k (k = 0..L-1).
  - data_out_inst is sampled at the end of cycle k into rdata[k].
  - Counter counts 0..L-1. The last cycle is k = L-1; the next state is UPDATE if cmd_update, else RESP.
- UPDATE: exactly 1 cycle; inst_update_en=1, inst_capture_en=0, inst_shift_dr=0.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are stable.
  - Bits rdata[MAX_LEN-1:L] = 0.
  - rsp_err=1 iff L==0. With L==0, capture/update are still honoured and no shift cycles occur.
  - Exits to IDLE on the cycle rsp_ready=1. rsp_valid drops next cycle.
- cmd_ready=0 in every state except IDLE. A command arriving during RESP stalls until IDLE (no same-cycle accept on response handshake).
- Latency: accept → rsp_valid = 1 + C + L + U cycles (C, U ∈ {0,1}).
- Enables are registered outputs with no glitches; outside the active state all enables are 0.
- Reset mid-operation: outputs go to reset values immediately; the partial shift is abandoned; no response is issued.
- cmd_chain pointing to an absent chain (LENn=0) is a legal command with rsp_err=1, not a hang.

Optional Feature:
Macro BSC_CTRL_PARITY_EN.
- Defined: adds output rsp_parity (1 bit) = XOR of rdata[L-1:0], valid with rsp_valid (0 when L=0). SHIFT additionally checks that after the last shift inst_data_in parity of wdata[L-1:0] was driven; no extra cycles are added.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then cmd chain=0 with capture=1, update=1, wdata=0x2D, and a bank model loopback → capture 1 cycle, shift 6 cycles driving bits 1,0,1,1,0,1; update 1 cycle; rsp_valid 9 cycles after accept; rsp_rdata equals the model's 6 captured bits, upper bits 0.
- cmd chain=1, capture=0, update=0, wdata=0x1F → exactly 5 SHIFT cycles, no capture_en-without-shift and no update_en; mux_select=1 throughout; rsp_err=0.
- cmd chain=2 (LEN2=0), capture=1, update=1 → CAPTURE, UPDATE, RESP; rsp_err=1, rsp_rdata=0, zero shift cycles.
- Hold rsp_ready=0 for 5 cycles with cmd_valid=1 → rsp_valid and rsp_rdata stable; cmd_ready=0; the next command is accepted only after RESP→IDLE.
- Assert reset on shift cycle 3 of chain 0 → all enables 0 in the same cycle, cmd_ready=1 after release, no rsp_valid; the next command completes normally.
- With BSC_CTRL_PARITY_EN, loopback returning 0b101101 → rsp_parity=0; returning 0b100000 → rsp_parity=1.

Source files
------------

// File: rtl/bsc_chain_scan_ctrl.sv
// Command sequencer for the four-way boundary-scan chain bank: capture, shift, update, respond.
// Optional BSC_CTRL_PARITY_EN adds rsp_parity (XOR of shifted-out bits) and a drive-parity check.
module bsc_chain_scan_ctrl #(
    parameter int LEN0    = 6,
    parameter int LEN1    = 5,
    parameter int LEN2    = 0,
    parameter int LEN3    = 0,
    parameter int MAX_LEN = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_chain,
    input  logic               cmd_capture,
    input  logic               cmd_update,
    input  logic               cmd_mode,
    input  logic [MAX_LEN-1:0] cmd_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_rdata,
    output logic               rsp_err,
    output logic [1:0]         mux_select,
    output logic               inst_capture_en,
    output logic               inst_update_en,
    output logic               inst_shift_dr,
    output logic               inst_mode,
    output logic               inst_data_in,
    input  logic               data_out_inst
`ifdef BSC_CTRL_PARITY_EN
    ,
    output logic               rsp_parity
`endif
);
    localparam int CW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);

    generate
        if (LEN0 < 0 || LEN1 < 0 || LEN2 < 0 || LEN3 < 0 ||
            LEN0 > MAX_LEN || LEN1 > MAX_LEN || LEN2 > MAX_LEN || LEN3 > MAX_LEN) begin : g_len_chk
            $error("bsc_chain_scan_ctrl: every LENn must be within 0..MAX_LEN");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, UPDATE, RESP} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [LW-1:0]      len_q, len_sel;
    logic               upd_q;
    logic [MAX_LEN-1:0] wdata_q, wsrc;
    logic               accept;

    function automatic logic [LW-1:0] len_of(input logic [1:0] c);
        case (c)
            2'd0:    len_of = LW'(LEN0);
            2'd1:    len_of = LW'(LEN1);
            2'd2:    len_of = LW'(LEN2);
            default: len_of = LW'(LEN3);
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        accept    = cmd_valid && cmd_ready;
        len_sel   = len_of(cmd_chain);
        wsrc      = accept ? cmd_wdata : wdata_q;
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_capture)          state_nxt = CAPTURE;
                    else if (len_sel != '0)   state_nxt = SHIFT;
                    else if (cmd_update)      state_nxt = UPDATE;
                    else                      state_nxt = RESP;
                end
            end
            CAPTURE: begin
                if (len_q != '0) state_nxt = SHIFT;
                else             state_nxt = upd_q ? UPDATE : RESP;
            end
            SHIFT: begin
                if (LW'(cnt) == len_q - LW'(1)) state_nxt = upd_q ? UPDATE : RESP;
                else                            cnt_nxt   = cnt + CW'(1);
            end
            UPDATE:  state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state and never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_ready       <= 1'b1;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_err         <= 1'b0;
            mux_select      <= '0;
            inst_capture_en <= 1'b0;
            inst_update_en  <= 1'b0;
            inst_shift_dr   <= 1'b0;
            inst_mode       <= 1'b0;
            inst_data_in    <= 1'b0;
            wdata_q         <= '0;
            len_q           <= '0;
            upd_q           <= 1'b0;
        end else begin
            cmd_ready       <= (state_nxt == IDLE);
            rsp_valid       <= (state_nxt == RESP);
            inst_capture_en <= (state_nxt == CAPTURE) || (state_nxt == SHIFT);
            inst_shift_dr   <= (state_nxt == SHIFT);
            inst_update_en  <= (state_nxt == UPDATE);
            inst_data_in    <= (state_nxt == SHIFT) && wsrc[cnt_nxt];
            if (accept) begin
                wdata_q    <= cmd_wdata;
                len_q      <= len_sel;
                upd_q      <= cmd_update;
                mux_select <= cmd_chain;
                inst_mode  <= cmd_mode;
                rsp_rdata  <= '0;
                rsp_err    <= (len_sel == '0);
            end else if (state_nxt == IDLE) begin
                mux_select <= '0;
                inst_mode  <= 1'b0;
                rsp_rdata  <= '0;
                rsp_err    <= 1'b0;
            end
            if (state == SHIFT)
                rsp_rdata[cnt] <= data_out_inst;
        end
    end

`ifdef BSC_CTRL_PARITY_EN
    logic tx_par;
    logic wpar;

    always_comb begin
        wpar = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (LW'(i) < len_q) wpar = wpar ^ wdata_q[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_parity <= 1'b0;
            tx_par     <= 1'b0;
        end else if (accept || state_nxt == IDLE) begin
            rsp_parity <= 1'b0;
            tx_par     <= 1'b0;
        end else if (state == SHIFT) begin
            rsp_parity <= rsp_parity ^ data_out_inst;
            tx_par     <= tx_par ^ inst_data_in;
            // Driven serial stream must carry exactly the parity of the requested write bits.
            if (LW'(cnt) == len_q - LW'(1))
                assert ((tx_par ^ inst_data_in) == wpar);
        end
    end
`endif
endmodule

// File: tb/tb_bsc_chain_scan_ctrl.sv
// Randomized bench for bsc_chain_scan_ctrl with a behavioural chain bank and vector-level scan model.
module tb_bsc_chain_scan_ctrl;
    localparam int ML = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_capture, cmd_update, cmd_mode;
    logic [1:0]    cmd_chain;
    logic [ML-1:0] cmd_wdata, rsp_rdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [1:0]    mux_select;
    logic          inst_capture_en, inst_update_en, inst_shift_dr, inst_mode, inst_data_in;
    logic          data_out_inst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bsc_chain_scan_ctrl #(.LEN0(6), .LEN1(5), .LEN2(0), .LEN3(0), .MAX_LEN(ML)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_chain(cmd_chain),
        .cmd_capture(cmd_capture), .cmd_update(cmd_update), .cmd_mode(cmd_mode),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mux_select(mux_select), .inst_capture_en(inst_capture_en), .inst_update_en(inst_update_en),
        .inst_shift_dr(inst_shift_dr), .inst_mode(inst_mode), .inst_data_in(inst_data_in),
        .data_out_inst(data_out_inst)
    );

    function automatic int tb_len(input logic [1:0] c);
        case (c)
            2'd0:    return 6;
            2'd1:    return 5;
            default: return 0;
        endcase
    endfunction

    function automatic logic [ML-1:0] mask(input int l);
        logic [31:0] m;
        m = (32'd1 << l) - 32'd1;
        return m[ML-1:0];
    endfunction

    function automatic logic [ML-1:0] shift_in(input logic [ML-1:0] v, input logic b, input int l);
        logic [ML-1:0] r;
        r = v >> 1;
        if (l > 0) r[l-1] = b;
        return r;
    endfunction

    // Chain bank: LSB is the serial output cell, new bits enter at the far end.
    logic [ML-1:0] bank    [4] = '{default: '0};
    logic [ML-1:0] upd_reg [4] = '{default: '0};
    logic [ML-1:0] pins    [4] = '{default: '0};

    assign data_out_inst = bank[mux_select][0];

    always @(posedge clk) begin
        if (inst_capture_en && inst_shift_dr)
            bank[mux_select] <= shift_in(bank[mux_select], inst_data_in, tb_len(mux_select));
        else if (inst_capture_en)
            bank[mux_select] <= pins[mux_select] & mask(tb_len(mux_select));
        if (inst_update_en)
            upd_reg[mux_select] <= bank[mux_select];
    end

    // Reference: what each chain currently holds, at whole-vector granularity.
    logic [ML-1:0] content [4];
    bit            known   [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] ch, input bit cap, input bit upd, input bit md,
                           input logic [ML-1:0] wd, input int hold, input bit stall);
        int l, ncyc, k, bad_seq, bad_din, bad_sel, bad_hold, w;
        logic [2:0]    code, exp_code;
        logic [ML-1:0] exp_rd;
        l = tb_len(ch);
        if (!known[ch]) cap = 1'b1;
        pins[ch] = ML'($urandom) & mask(l);
        exp_rd = (cap ? pins[ch] : content[ch]) & mask(l);

        w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_chain = ch; cmd_capture = cap; cmd_update = upd;
        cmd_mode = md; cmd_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_wdata = ML'($urandom);

        bad_seq = 0; bad_din = 0; bad_sel = 0; ncyc = 1;
        while (rsp_valid !== 1'b1 && ncyc < 60) begin
            k = ncyc - 1;
            code = {inst_capture_en, inst_shift_dr, inst_update_en};
            if (k < int'(cap))               exp_code = 3'b100;
            else if (k < int'(cap) + l)      exp_code = 3'b110;
            else if (k < int'(cap) + l + int'(upd)) exp_code = 3'b001;
            else                             exp_code = 3'b000;
            if (code !== exp_code) bad_seq++;
            if (exp_code == 3'b110 && inst_data_in !== wd[k - int'(cap)]) bad_din++;
            if (mux_select !== ch || inst_mode !== md || cmd_ready !== 1'b0) bad_sel++;
            @(negedge clk);
            ncyc++;
        end
        chk("latency", ncyc, 1 + int'(cap) + l + int'(upd));
        chk("phase_seq", bad_seq, 0);
        chk("data_in", bad_din, 0);
        chk("sel_mode", bad_sel, 0);
        chk("rdata", rsp_rdata, exp_rd);
        chk("err", rsp_err, (l == 0));
        chk("bank_wr", bank[ch], wd & mask(l));
        if (upd) chk("update", upd_reg[ch], wd & mask(l));
        content[ch] = wd & mask(l);

        if (stall) begin
            cmd_valid = 1'b1; cmd_chain = 2'($urandom); cmd_capture = 1'b1;
        end
        bad_hold = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || cmd_ready !== 1'b0 ||
                inst_capture_en !== 1'b0 || inst_update_en !== 1'b0) bad_hold++;
        end
        chk("hold", bad_hold, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("rsp_exit", {rsp_valid, cmd_ready, inst_capture_en, inst_update_en}, 4'b0100);
    endtask

    task automatic reset_mid_shift();
        int quiet;
        known[0] = 1'b0;
        cmd_valid = 1'b1; cmd_chain = 2'd0; cmd_capture = 1'b1; cmd_update = 1'b1;
        cmd_mode = 1'b1; cmd_wdata = ML'($urandom);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_shift", {inst_capture_en, inst_shift_dr}, 2'b11);
        reset = 1'b1;
        #1;
        chk("rst_async", {inst_capture_en, inst_shift_dr, inst_update_en, inst_data_in,
                          inst_mode, mux_select, rsp_valid, cmd_ready}, 9'b000000001);
        @(negedge clk);
        reset = 1'b0;
        quiet = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) quiet++;
        end
        chk("post_rst_idle", quiet, 0);
    endtask

    initial begin
        for (int c = 0; c < 4; c++) begin
            content[c] = '0;
            known[c]   = 1'b1;
        end
        reset = 1'b1; cmd_valid = 1'b0; cmd_chain = '0; cmd_capture = 1'b0; cmd_update = 1'b0;
        cmd_mode = 1'b0; cmd_wdata = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_outs", {rsp_valid, rsp_err, mux_select, inst_capture_en, inst_update_en,
                         inst_shift_dr, inst_mode, inst_data_in}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        reset = 1'b0;
        @(negedge clk);

        run_cmd(2'd0, 1'b1, 1'b1, 1'b0, 16'h002D, 0, 1'b0);
        run_cmd(2'd1, 1'b0, 1'b0, 1'b1, 16'h001F, 1, 1'b0);
        run_cmd(2'd2, 1'b1, 1'b1, 1'b0, 16'hFFFF, 0, 1'b0);
        run_cmd(2'd0, 1'b0, 1'b1, 1'b1, 16'hA5C3, 5, 1'b1);
        run_cmd(2'd3, 1'b0, 1'b0, 1'b0, 16'h1234, 2, 1'b0);
        reset_mid_shift();
        run_cmd(2'd0, 1'b1, 1'b0, 1'b0, 16'h0013, 0, 1'b0);

        for (int n = 0; n < 40; n++)
            run_cmd(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ML'($urandom),
                    $urandom_range(0, 3), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
